// File: rtl/rice_bit_parser_pkg.sv
// Shared types and constants for the Rice codeword bit parser.
package rice_bit_parser_pkg;

    localparam int unsigned RP_W = 4;

    // Rice parameter value reserved as the escape code; handled by the partition controller.
    localparam logic [RP_W-1:0] ESC_PARAM = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNARY  = 2'd1,
        ST_BINARY = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/rice_bit_parser_if.sv
// Bit-stream input, partition control and codeword output bundle of the Rice parser.
interface rice_bit_parser_if #(
    parameter int unsigned W = 16
);
    import rice_bit_parser_pkg::*;

    logic            iStart;
    logic [RP_W-1:0] iRiceParam;
    logic [W-1:0]    iCount;
    logic            iBit;
    logic            iValid;
    logic            oReady;
    logic [W-1:0]    oMSB;
    logic [W-1:0]    oLSB;
    logic [RP_W-1:0] oRiceParam;
    logic            oValid;
    logic            iReady;
    logic            oDone;
    logic            oOverflow;

    // Upstream/downstream side: drives stream and control, consumes codewords.
    modport master (
        output iStart, iRiceParam, iCount, iBit, iValid, iReady,
        input  oReady, oMSB, oLSB, oRiceParam, oValid, oDone, oOverflow
    );

    // Parser side.
    modport slave (
        input  iStart, iRiceParam, iCount, iBit, iValid, iReady,
        output oReady, oMSB, oLSB, oRiceParam, oValid, oDone, oOverflow
    );

endinterface

// File: rtl/rice_bit_parser.sv
// Splits a serial Rice-coded residual stream into quotient/remainder codewords for one partition.
module rice_bit_parser
    import rice_bit_parser_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input logic                 iClock,
    input logic                 iReset_n,
    rice_bit_parser_if.slave    bus
);

    state_e          state_q, state_d;
    logic [W-1:0]    msb_q, msb_d;
    logic [W-1:0]    lsb_q, lsb_d;
    logic [W-1:0]    count_q, count_d;
    logic [RP_W-1:0] param_q, param_d;
    logic [RP_W-1:0] bit_cnt_q, bit_cnt_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign accept = bus.iValid && ready_q;

    // Next-state and datapath update; ready/valid are registered decodes of the next state.
    always_comb begin
        state_d   = state_q;
        msb_d     = msb_q;
        lsb_d     = lsb_q;
        count_d   = count_q;
        param_d   = param_q;
        bit_cnt_d = bit_cnt_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    if (bus.iCount != '0) begin
                        param_d = bus.iRiceParam;
                        count_d = bus.iCount;
                        msb_d   = '0;
                        lsb_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_UNARY;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_UNARY: begin
                if (accept) begin
                    if (!bus.iBit) begin
                        if (msb_q != {W{1'b1}}) begin
                            msb_d = msb_q + W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (param_q == '0) begin
                        lsb_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = param_q;
                        state_d   = ST_BINARY;
                    end
                end
            end
            ST_BINARY: begin
                if (accept) begin
                    lsb_d     = {lsb_q[W-2:0], bus.iBit};
                    bit_cnt_d = bit_cnt_q - RP_W'(1);
                    if (bit_cnt_q == RP_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.iReady) begin
                    count_d = count_q - W'(1);
                    if (count_q == W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        msb_d   = '0;
                        lsb_d   = '0;
                        state_d = ST_UNARY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_UNARY) || (state_d == ST_BINARY);
        valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= ST_IDLE;
            msb_q     <= '0;
            lsb_q     <= '0;
            count_q   <= '0;
            param_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            count_q   <= count_d;
            param_q   <= param_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.oReady     = ready_q;
    assign bus.oMSB       = msb_q;
    assign bus.oLSB       = lsb_q;
    assign bus.oRiceParam = param_q;
    assign bus.oValid     = valid_q;
    assign bus.oDone      = done_q;
    assign bus.oOverflow  = ovf_q;

endmodule

// File: tb/tb_rice_bit_parser.sv
// Self-checking bench for rice_bit_parser: codeword model queue plus directed literal checks.
module tb_rice_bit_parser;
    import rice_bit_parser_pkg::*;

    localparam int unsigned W = 16;
    localparam longint MAXQ = (64'd1 << W) - 1;

    logic iClock   = 1'b0;
    logic iReset_n = 1'b0;

    always #5 iClock = ~iClock;

    rice_bit_parser_if #(.W(W)) bus ();

    rice_bit_parser #(.W(W)) dut (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    typedef struct {
        logic [W-1:0] msb;
        logic [W-1:0] lsb;
        logic [3:0]   param;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           done_cnt    = 0;
    logic         done_prev   = 1'b0;
    logic [W-1:0] last_msb    = '0;
    logic [W-1:0] last_lsb    = '0;
    logic [3:0]   last_param  = '0;
    int           cur_param   = 0;
    logic         part_ovf    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every held codeword against the model queue; retire on handshake.
    always @(negedge iClock) begin
        if (iReset_n) begin
            if (bus.oValid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got msb %0h lsb %0h, none expected", bus.oMSB, bus.oLSB);
                end else begin
                    chk("msb", bus.oMSB, exp_q[0].msb);
                    chk("lsb", bus.oLSB, exp_q[0].lsb);
                    chk("param", bus.oRiceParam, exp_q[0].param);
                    chk("ovf", bus.oOverflow, exp_q[0].ovf);
                    chk("ready_in_hold", bus.oReady, 0);
                    if (bus.iReady) begin
                        last_msb   = bus.oMSB;
                        last_lsb   = bus.oLSB;
                        last_param = bus.oRiceParam;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.oDone) begin
                done_cnt++;
                chk("done_width", done_prev, 0);
            end
            done_prev = bus.oDone;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic do_start(input int param, input int count);
        bus.iStart     = 1'b1;
        bus.iRiceParam = 4'(param);
        bus.iCount     = W'(count);
        if (count != 0) begin
            cur_param = param;
            part_ovf  = 1'b0;
        end
        tick();
        bus.iStart = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        int g;
        int guard;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        if (g > 0) begin
            bus.iValid = 1'b0;
            repeat (g) tick();
        end
        bus.iBit   = b;
        bus.iValid = 1'b1;
        guard = 0;
        while (!bus.oReady && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL bit_accept_timeout: got oReady 0 for %0d cycles, required 1", guard);
        end
        tick();
    endtask

    // Queue the expected codeword, then serialise q zeros, a 1 and the k remainder bits.
    task automatic send_codeword(input longint q, input int r, input int maxgap);
        exp_t e;
        logic [W-1:0] rv;
        rv = W'(r);
        if (q > MAXQ) part_ovf = 1'b1;
        e.msb   = (q > MAXQ) ? W'(MAXQ) : W'(q);
        e.lsb   = (cur_param == 0) ? '0 : W'(r & ((1 << cur_param) - 1));
        e.param = 4'(cur_param);
        e.ovf   = part_ovf;
        exp_q.push_back(e);
        for (longint i = 0; i < q; i++) send_bit(1'b0, maxgap);
        send_bit(1'b1, maxgap);
        for (int i = cur_param - 1; i >= 0; i--) send_bit(rv[i], maxgap);
        bus.iValid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d codewords pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.iStart     = 1'b0;
        bus.iRiceParam = '0;
        bus.iCount     = '0;
        bus.iBit       = 1'b0;
        bus.iValid     = 1'b0;
        bus.iReady     = 1'b1;
        repeat (3) tick();
        chk("rst_valid", bus.oValid, 0);
        chk("rst_ready", bus.oReady, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_ovf", bus.oOverflow, 0);
        chk("rst_msb", bus.oMSB, 0);
        iReset_n = 1'b1;
        tick();

        // Param 2, count 1: bits 0,0,1,1,0.
        d0 = done_cnt;
        do_start(2, 1);
        send_codeword(2, 2, 0);
        chk("t1_valid_after_last_bit", bus.oValid, 1);
        tick();
        chk("t1_done_pulse", bus.oDone, 1);
        chk("t1_valid_drop", bus.oValid, 0);
        tick();
        chk("t1_done_clear", bus.oDone, 0);
        chk("t1_msb_lit", last_msb, 2);
        chk("t1_lsb_lit", last_lsb, 2);
        chk("t1_param_lit", last_param, 2);
        chk("t1_done_count", done_cnt - d0, 1);

        // Param 0, count 1: bits 0,0,0,1.
        do_start(0, 1);
        send_codeword(3, 0, 0);
        chk("t2_valid_after_term", bus.oValid, 1);
        repeat (3) tick();
        chk("t2_msb_lit", last_msb, 3);
        chk("t2_lsb_lit", last_lsb, 0);

        // Backpressure: hold iReady low in HOLD with a bit offered.
        d0 = done_cnt;
        bus.iReady = 1'b0;
        do_start(1, 2);
        send_codeword(1, 1, 0);
        bus.iBit   = 1'b1;
        bus.iValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", bus.oReady, 0);
            chk("bp_valid", bus.oValid, 1);
            chk("bp_msb", bus.oMSB, 1);
        end
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        tick();
        send_codeword(2, 0, 0);
        repeat (3) tick();
        chk("bp_lsb_lit", last_lsb, 0);
        chk("bp_done_count", done_cnt - d0, 1);

        // Stalled input: param 3, count 3, random gaps.
        d0 = done_cnt;
        do_start(3, 3);
        send_codeword(1, 5, 3);
        send_codeword(0, 7, 3);
        send_codeword(4, 2, 3);
        repeat (4) tick();
        chk("stall_done_count", done_cnt - d0, 1);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Count 0 start.
        d0 = done_cnt;
        do_start(5, 0);
        chk("c0_done", bus.oDone, 1);
        chk("c0_valid", bus.oValid, 0);
        tick();
        chk("c0_done_clear", bus.oDone, 0);
        chk("c0_done_count", done_cnt - d0, 1);

        // Saturation: 70000 zeros, param 0.
        do_start(0, 1);
        send_codeword(70000, 0, 0);
        repeat (3) tick();
        chk("sat_msb_lit", last_msb, 16'hFFFF);
        chk("sat_ovf_lit", bus.oOverflow, 1);

        // Reset mid-BINARY: param 4, q=0, two of four remainder bits.
        d0 = done_cnt;
        do_start(4, 1);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        bus.iValid = 1'b0;
        iReset_n = 1'b0;
        #1;
        chk("rr_lsb", bus.oLSB, 0);
        chk("rr_param", bus.oRiceParam, 0);
        chk("rr_ready", bus.oReady, 0);
        chk("rr_valid", bus.oValid, 0);
        chk("rr_done", bus.oDone, 0);
        chk("rr_ovf", bus.oOverflow, 0);
        repeat (2) tick();
        iReset_n = 1'b1;
        repeat (4) tick();
        chk("rr_idle_ready", bus.oReady, 0);
        chk("rr_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
